// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD digit writer.
// Holds the FSM encoding and the bus select/lock levels.
package lcd_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_ADDR,
        S_DATA
    } state_e;

    localparam logic ADDR_SEL     = 1'b0;
    localparam logic DATA_SEL     = 1'b1;
    localparam logic BUS_LOCKED   = 1'b1;
    localparam logic BUS_UNLOCKED = 1'b0;

endpackage

// File: rtl/lcd_digit_writer.sv
// Writes a frame of digit patterns to an LCD as address/data beat pairs,
// optionally skipping digits that match what the panel already shows.
module lcd_digit_writer
    import lcd_pkg::*;
#(
    parameter int              NUM_DIGITS  = 5,
    parameter int              DATA_W      = 8,
    parameter logic [DATA_W-1:0] ADDR_BASE = '0,
    parameter bit              REFRESH_ALL = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         busLock,
    input  logic [NUM_DIGITS*DATA_W-1:0] digits,
    output logic [DATA_W-1:0]            lcdBus,
    output logic                         addrOrData,
    output logic                         busValid,
    output logic                         busy,
    output logic                         frameDone
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DIGITS - 1);

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [NUM_DIGITS*DATA_W-1:0]   snap_q, snap_d;
    logic [NUM_DIGITS*DATA_W-1:0]   shadow_q, shadow_d;
    logic                           shadow_valid_q, shadow_valid_d;
    logic [DATA_W-1:0]              bus_q, bus_d;
    logic                           aod_q, aod_d;
    logic                           valid_q, valid_d;
    logic                           done_q, done_d;

    logic [DATA_W-1:0] cur_snap;
    logic [DATA_W-1:0] cur_shadow;
    logic [DATA_W-1:0] cur_addr;
    logic              need_wr;
    logic              last;
    logic              unlocked;

    assign cur_snap   = snap_q[idx_q*DATA_W +: DATA_W];
    assign cur_shadow = shadow_q[idx_q*DATA_W +: DATA_W];
    assign cur_addr   = ADDR_BASE + DATA_W'(idx_q);
    assign last       = (idx_q == LAST);
    assign unlocked   = (busLock == BUS_UNLOCKED);
    assign need_wr    = REFRESH_ALL || !shadow_valid_q ||
                        (cur_snap != cur_shadow);

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        snap_d         = snap_q;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        bus_d          = bus_q;
        aod_d          = aod_q;
        valid_d        = 1'b0;
        done_d         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    snap_d  = digits;
                    idx_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (need_wr) begin
                    state_d = S_ADDR;
                end else if (last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_ADDR: begin
                if (unlocked) begin
                    bus_d   = cur_addr;
                    aod_d   = ADDR_SEL;
                    valid_d = 1'b1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (unlocked) begin
                    bus_d   = cur_snap;
                    aod_d   = DATA_SEL;
                    valid_d = 1'b1;
                    shadow_d[idx_q*DATA_W +: DATA_W] = cur_snap;
                    if (last) begin
                        state_d        = S_IDLE;
                        done_d         = 1'b1;
                        shadow_valid_d = 1'b1;
                    end else begin
                        state_d = S_SCAN;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            snap_q         <= '0;
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
            bus_q          <= '0;
            aod_q          <= 1'b0;
            valid_q        <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            snap_q         <= snap_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
            bus_q          <= bus_d;
            aod_q          <= aod_d;
            valid_q        <= valid_d;
            done_q         <= done_d;
        end
    end

    assign lcdBus     = bus_q;
    assign addrOrData = aod_q;
    assign busValid   = valid_q;
    assign frameDone  = done_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_lcd_digit_writer.sv
// Randomised and directed bench for lcd_digit_writer against a
// frame-level model of which digits get written and how long it takes.
module tb_lcd_digit_writer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic busLock = 1'b0;
    logic en16 = 1'b0;
    logic lock16 = 1'b0;
    logic [39:0]  digits5  = '0;
    logic [127:0] digits16 = '0;

    logic [7:0] bus5, bus16;
    logic aod5, bv5, busy5, fd5;
    logic aod16, bv16, busy16, fd16;

    int checks = 0;
    int failures = 0;
    int lock_viol = 0;

    logic [8:0] got5[$];
    logic [8:0] exp5[$];
    logic [8:0] got16[$];

    logic [7:0] m_shadow[5];
    bit         m_valid = 1'b0;
    logic       mon_lk;

    always #5 clk = ~clk;

    lcd_digit_writer #(
        .NUM_DIGITS(5), .DATA_W(8), .ADDR_BASE(8'h00), .REFRESH_ALL(1'b0)
    ) dut5 (
        .clk(clk), .rst(rst), .enable(enable), .busLock(busLock),
        .digits(digits5), .lcdBus(bus5), .addrOrData(aod5),
        .busValid(bv5), .busy(busy5), .frameDone(fd5)
    );

    lcd_digit_writer #(
        .NUM_DIGITS(16), .DATA_W(8), .ADDR_BASE(8'hF8), .REFRESH_ALL(1'b1)
    ) dut16 (
        .clk(clk), .rst(rst), .enable(en16), .busLock(lock16),
        .digits(digits16), .lcdBus(bus16), .addrOrData(aod16),
        .busValid(bv16), .busy(busy16), .frameDone(fd16)
    );

    always @(posedge clk) begin
        mon_lk = busLock;
        #1;
        if (bv5) begin
            got5.push_back({aod5, bus5});
            if (mon_lk) lock_viol++;
        end
        if (bv16) got16.push_back({aod16, bus16});
    end

    // Expected beats and written-digit count for one frame of dut5.
    function automatic int model5(input logic [39:0] d);
        int w = 0;
        for (int i = 0; i < 5; i++) begin
            logic [7:0] b;
            b = d[i*8 +: 8];
            if (!m_valid || b != m_shadow[i]) begin
                exp5.push_back({1'b0, 8'(i)});
                exp5.push_back({1'b1, b});
                m_shadow[i] = b;
                w++;
            end
        end
        m_valid = 1'b1;
        return w;
    endfunction

    function automatic bit beats_match();
        if (got5.size() != exp5.size()) return 1'b0;
        foreach (exp5[i]) if (got5[i] !== exp5[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_frame5(input bit rnd_lock, input logic [39:0] mid,
                              output int cyc, output bit to);
        got5.delete();
        @(negedge clk);
        enable = 1'b1;
        cyc = 0;
        to = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (k == 0) enable = 1'b0;
            if (fd5) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
            busLock = rnd_lock ? ($urandom_range(2) == 0) : 1'b0;
            if (k == 2) digits5 = mid;
        end
        @(negedge clk);
        busLock = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (busy5 !== 1'b0) begin
            failures++; $display("FAIL rst_busy got=%b exp=0", busy5);
        end
        checks++;
        if (bv5 !== 1'b0 || fd5 !== 1'b0) begin
            failures++; $display("FAIL rst_strobes bv=%b fd=%b exp=0/0", bv5, fd5);
        end
        checks++;
        if (bus5 !== 8'h00 || aod5 !== 1'b0) begin
            failures++; $display("FAIL rst_bus got=%h/%b exp=00/0", bus5, aod5);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy5 !== 1'b0) begin
            failures++; $display("FAIL idle_hold busy=%b exp=0", busy5);
        end
        m_valid = 1'b0;
    endtask

    task automatic frame_check(input string nm, input int exp_cyc);
        int cyc;
        bit to;
        run_frame5(1'b0, digits5, cyc, to);
        checks++;
        if (to || cyc != exp_cyc) begin
            failures++;
            $display("FAIL %s_cycles got=%0d exp=%0d timeout=%0d", nm, cyc, exp_cyc, to);
        end
        checks++;
        if (!beats_match()) begin
            failures++;
            $display("FAIL %s_beats got_n=%0d exp_n=%0d", nm, got5.size(), exp5.size());
        end
    endtask

    task automatic test_first_frame();
        int w;
        digits5 = 40'h05_04_03_02_01;
        exp5.delete();
        w = model5(digits5);
        frame_check("first", 1 + 5 + 2 * w);
        checks++;
        if (exp5.size() != 10 || got5.size() != 10 || got5[9] !== 9'h105) begin
            failures++;
            $display("FAIL first_last got_n=%0d exp_last=105", got5.size());
        end
    endtask

    task automatic test_no_change();
        int w;
        exp5.delete();
        w = model5(digits5);
        frame_check("nochange", 6 + 2 * w);
    endtask

    task automatic test_one_change();
        int w;
        digits5[23:16] = 8'h3F;
        exp5.delete();
        w = model5(digits5);
        frame_check("onechg", 6 + 2 * w);
    endtask

    task automatic test_bus_lock();
        int w, a1_edge, cyc, lock_beats, held_bad;
        logic [7:0] held;
        digits5 = digits5 ^ 40'h11_11_11_11_11;
        held = digits5[7:0];
        exp5.delete();
        w = model5(digits5);
        got5.delete();
        a1_edge = -1; cyc = -1; lock_beats = 0; held_bad = 0;
        @(negedge clk);
        enable = 1'b1;
        for (int e = 0; e < 100; e++) begin
            @(posedge clk);
            #1;
            if (e == 0) enable = 1'b0;
            if (bv5 && !aod5 && bus5 == 8'h01) a1_edge = e;
            if (e >= 5 && e <= 8) begin
                if (bv5) lock_beats++;
                if (bus5 !== held) held_bad++;
            end
            if (fd5) begin
                cyc = e + 1;
                break;
            end
            @(negedge clk);
            busLock = (e >= 4 && e <= 7);
        end
        @(negedge clk);
        busLock = 1'b0;
        checks++;
        if (lock_beats != 0 || held_bad != 0) begin
            failures++;
            $display("FAIL lock_hold beats=%0d bus_changes=%0d exp=0/0", lock_beats, held_bad);
        end
        checks++;
        if (a1_edge != 9) begin
            failures++; $display("FAIL lock_delay addr1_edge=%0d exp=9", a1_edge);
        end
        checks++;
        if (cyc != 1 + 5 + 2 * w + 4) begin
            failures++; $display("FAIL lock_cycles got=%0d exp=%0d", cyc, 20);
        end
        checks++;
        if (!beats_match()) begin
            failures++; $display("FAIL lock_beats got_n=%0d exp_n=%0d", got5.size(), exp5.size());
        end
    endtask

    task automatic test_reset_mid();
        int w, early_done;
        digits5 = digits5 ^ 40'hA5_A5_A5_A5_A5;
        got5.delete();
        early_done = 0;
        @(negedge clk);
        enable = 1'b1;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            if (e == 0) enable = 1'b0;
            if (fd5) early_done++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (fd5) early_done++;
        end
        @(negedge clk);
        checks++;
        if (early_done != 0 || busy5 !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_abandon done=%0d busy=%b exp=0/0", early_done, busy5);
        end
        checks++;
        if (got5.size() != 7) begin
            failures++; $display("FAIL rstmid_partial got_n=%0d exp_n=7", got5.size());
        end
        rst = 1'b1;
        m_valid = 1'b0;
        exp5.delete();
        w = model5(digits5);
        frame_check("rstmid", 6 + 2 * w);
    endtask

    task automatic test_back_to_back();
        int w1, w2, n, n1, n2;
        digits5[39:32] = digits5[39:32] ^ 8'h5A;
        exp5.delete();
        w1 = model5(digits5);
        w2 = model5(digits5);
        got5.delete();
        n = 0; n1 = -1; n2 = -1;
        @(negedge clk);
        enable = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (n1 >= 0 && n == n1 + 1) begin
                checks++;
                if (busy5 !== 1'b1) begin
                    failures++; $display("FAIL b2b_start busy=%b exp=1", busy5);
                end
                enable = 1'b0;
            end
            if (fd5) begin
                if (n1 < 0) n1 = n;
                else begin
                    n2 = n;
                    break;
                end
            end
        end
        @(negedge clk);
        enable = 1'b0;
        checks++;
        if (n2 - n1 != 6 + 2 * w2 || n1 != 6 + 2 * w1) begin
            failures++;
            $display("FAIL b2b_timing f1=%0d gap=%0d exp=%0d/%0d", n1, n2 - n1, 6 + 2 * w1, 6);
        end
        checks++;
        if (!beats_match()) begin
            failures++; $display("FAIL b2b_beats got_n=%0d exp_n=%0d", got5.size(), exp5.size());
        end
    endtask

    task automatic test_random();
        int w, cyc, bad_cyc, bad_beats, tos;
        bit to, rl;
        logic [39:0] d;
        bad_cyc = 0; bad_beats = 0; tos = 0;
        for (int f = 0; f < 16; f++) begin
            d = digits5;
            for (int i = 0; i < 5; i++)
                if ($urandom_range(1) == 1)
                    d[i*8 +: 8] = d[i*8 +: 8] ^ 8'($urandom_range(255, 1));
            digits5 = d;
            rl = f[0];
            exp5.delete();
            w = model5(d);
            run_frame5(rl, 40'($urandom) ^ {8'($urandom), 32'h0}, cyc, to);
            if (to) tos++;
            if (!rl && cyc != 6 + 2 * w) bad_cyc++;
            if (!beats_match()) bad_beats++;
        end
        checks++;
        if (tos != 0 || bad_cyc != 0) begin
            failures++; $display("FAIL rand_cycles timeouts=%0d bad=%0d exp=0/0", tos, bad_cyc);
        end
        checks++;
        if (bad_beats != 0) begin
            failures++; $display("FAIL rand_beats bad_frames=%0d exp=0", bad_beats);
        end
        checks++;
        if (lock_viol != 0) begin
            failures++; $display("FAIL lock_violation beats=%0d exp=0", lock_viol);
        end
    endtask

    task automatic test_wrap16();
        logic [8:0] exp16[$];
        int cyc, bad;
        for (int r = 0; r < 2; r++) begin
            digits16 = {$urandom, $urandom, $urandom, $urandom};
            exp16.delete();
            for (int i = 0; i < 16; i++) begin
                exp16.push_back({1'b0, 8'(8'hF8 + i)});
                exp16.push_back({1'b1, digits16[i*8 +: 8]});
            end
            got16.delete();
            cyc = -1;
            @(negedge clk);
            en16 = 1'b1;
            for (int e = 0; e < 200; e++) begin
                @(posedge clk);
                #1;
                if (e == 0) en16 = 1'b0;
                if (fd16) begin
                    cyc = e + 1;
                    break;
                end
            end
            @(negedge clk);
            bad = 0;
            if (got16.size() != exp16.size()) bad = 1;
            else foreach (exp16[i]) if (got16[i] !== exp16[i]) bad++;
            checks++;
            if (cyc != 49) begin
                failures++; $display("FAIL wrap_cycles round=%0d got=%0d exp=49", r, cyc);
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL wrap_beats round=%0d got_n=%0d exp_n=32 bad=%0d", r, got16.size(), bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_no_change();
        test_one_change();
        test_bus_lock();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_wrap16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
